branch_predict_unit: RTL

- Parametrised successor to the decode-stage branch/jump resolver.
- Adds a direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating counters, so fetch can predict the next PC.
- Resolved outcomes from decode train the table, raise mispredict/redirect to flush fetch, and drive saturating performance counters.
- Sits between the fetch PC mux and the decode-stage branch/jump resolution logic.

---
 rtl/branch_predict_unit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/branch_predict_unit.sv
// Fetch-side branch predictor: a direct-mapped BTB with 2-bit counters, trained
// by resolved decode-stage outcomes, plus mispredict redirect and saturating perf counters.
module branch_predict_unit #(
    parameter int PC_W  = 16,
    parameter int IDX_W = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  fetch_pc,
    output logic             pred_taken,
    output logic [PC_W-1:0]  pred_target,
    input  logic             upd_en,
    input  logic             upd_jump,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [PC_W-1:0]  upd_target,
    input  logic             upd_pred_taken,
    input  logic [PC_W-1:0]  upd_pred_target,
    output logic             mispredict,
    output logic [PC_W-1:0]  redirect_pc,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt,
    output logic             err
);
    localparam int ENTRIES = 2 ** IDX_W;
    localparam int TAG_W   = PC_W - IDX_W - 1;

    logic [ENTRIES-1:0] validQ;
    logic [TAG_W-1:0]   tagQ    [ENTRIES];
    logic [PC_W-1:0]    targetQ [ENTRIES];
    logic [1:0]         ctrQ    [ENTRIES];

    logic [IDX_W-1:0] fetchIdx;
    logic [TAG_W-1:0] fetchTag;
    logic             fetchHit;

    logic [IDX_W-1:0] updIdx;
    logic [TAG_W-1:0] updTag;
    logic             updHit;
    logic             updValid;
    logic [PC_W-1:0]  correctNext;

    logic             wrEn;
    logic [PC_W-1:0]  wrTarget;
    logic [1:0]       wrCtr;

    // The prediction carried with the instruction is implied by upd_pred_target.
    logic unusedPredTaken;
    assign unusedPredTaken = upd_pred_taken;

    // Lookup reads the flops directly, so a same-cycle update is seen only next cycle.
    assign fetchIdx    = fetch_pc[IDX_W:1];
    assign fetchTag    = fetch_pc[PC_W-1:IDX_W+1];
    assign fetchHit    = validQ[fetchIdx] && (tagQ[fetchIdx] == fetchTag);
    assign pred_taken  = fetchHit && ctrQ[fetchIdx][1];
    assign pred_target = pred_taken ? targetQ[fetchIdx] : fetch_pc + PC_W'(2);

    assign updIdx = upd_pc[IDX_W:1];
    assign updTag = upd_pc[PC_W-1:IDX_W+1];
    assign updHit = validQ[updIdx] && (tagQ[updIdx] == updTag);

    assign err         = upd_en && (upd_pc[0] || (upd_taken && upd_target[0]) || (upd_jump && !upd_taken));
    assign updValid    = upd_en && !err;
    assign correctNext = upd_taken ? upd_target : upd_pc + PC_W'(2);
    assign redirect_pc = upd_en ? correctNext : '0;
    assign mispredict  = updValid && (correctNext != upd_pred_target);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wrEn     = 1'b0;
        wrTarget = targetQ[updIdx];
        wrCtr    = ctrQ[updIdx];
        if (updValid) begin
            if (updHit) begin
                wrEn = 1'b1;
                if (upd_taken) begin
                    wrTarget = upd_target;
                    if (ctrQ[updIdx] != 2'b11) wrCtr = ctrQ[updIdx] + 2'b01;
                end else if (ctrQ[updIdx] != 2'b00) begin
                    wrCtr = ctrQ[updIdx] - 2'b01;
                end
            end else if (upd_taken) begin
                wrEn     = 1'b1;
                wrTarget = upd_target;
                wrCtr    = 2'b10;
            end
            if (upd_jump) wrCtr = 2'b11;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            validQ <= '0;
            for (int i = 0; i < ENTRIES; i++) ctrQ[i] <= 2'b01;
        end else if (wrEn) begin
            validQ[updIdx] <= 1'b1;
            ctrQ[updIdx]   <= wrCtr;
        end
    end

    // NOTE: tag/target storage is not reset; a cleared valid bit masks whatever it holds.
    always_ff @(posedge clk) begin
        if (!rst && wrEn) begin
            tagQ[updIdx]    <= updTag;
            targetQ[updIdx] <= wrTarget;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (updValid) begin
            if (branch_cnt != '1) branch_cnt <= branch_cnt + CNT_W'(1);
            if (mispredict && mispred_cnt != '1) mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
    end
endmodule
